// File: rtl/layer_mac_sched.sv
// rtl/layer_mac_sched.sv - time-multiplexed single-MAC dense layer scheduler
//
// Loads one frame of N_IN signed 8-bit activations, then evaluates N_NODES
// neurons in turn on a single 8-bit wrapping multiply-accumulate. Each neuron
// fetches its N_IN weights and one bias word from an external weight memory
// and emits a ReLU'd 8-bit result on a valid/ready stream.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   in_valid/in_ready    activation stream handshake, in_data 8-bit signed
//   w_rd_en/w_addr       weight memory read request, w_data returns 1 cycle later
//   out_valid/out_ready  result stream handshake, out_data 8-bit ReLU result
//   out_idx              neuron index of out_data
//   out_last             marks the result of neuron N_NODES-1
//   busy                 high while computing or presenting results

module layer_mac_sched #(
    parameter int N_IN    = 30,
    parameter int N_NODES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        w_rd_en,
    output logic [12:0] w_addr,
    input  logic [7:0]  w_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    // Activation buffer index width; the buffer is rounded up to a power of
    // two so every index value of that width addresses a real entry.
    localparam int AW = $clog2(N_IN);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state;
    logic [AW-1:0] cnt;     // activation write pointer during LOAD
    logic [AW-1:0] rptr;    // activation read pointer matching returning weights
    logic [8:0]  kcnt;      // cycles spent in the current RUN (0..N_IN+1)
    logic [3:0]  node;      // neuron currently being evaluated
    logic [7:0]  acc;       // 8-bit wrapping accumulator

    logic [7:0]  act_buf [0:(1<<AW)-1];

    logic [7:0]  act_sel;
    logic [7:0]  prod;
    logic [7:0]  sum;

    // Only the low 8 bits of the product are kept, and those are identical
    // for signed and unsigned operands, so a plain 8-bit multiply suffices.
    assign act_sel = act_buf[rptr];
    assign prod    = act_sel * w_data;
    assign sum     = acc + w_data;

    // Activation storage: no reset, every entry is rewritten each frame
    // before RUN reads it.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid && in_ready) begin
            act_buf[cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            cnt       <= '0;
            rptr      <= '0;
            kcnt      <= '0;
            node      <= '0;
            acc       <= '0;
            in_ready  <= 1'b0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (in_valid && in_ready) begin
                        if (cnt == AW'(N_IN - 1)) begin
                            // Last beat: start neuron 0 with the first weight
                            // request issued on the very first RUN cycle.
                            state    <= RUN;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            node     <= '0;
                            acc      <= '0;
                            kcnt     <= '0;
                            rptr     <= '0;
                            w_rd_en  <= 1'b1;
                            w_addr   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                RUN: begin
                    kcnt <= kcnt + 1'b1;

                    // Requests cover k = 0..N_IN (N_IN weights plus the bias).
                    // Addresses of consecutive neurons are contiguous, so the
                    // address simply keeps counting.
                    if (kcnt < 9'(N_IN)) begin
                        w_rd_en <= 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end else begin
                        w_rd_en <= 1'b0;
                    end

                    // Data for request k arrives when kcnt == k+1.
                    if (kcnt >= 9'd1 && kcnt <= 9'(N_IN)) begin
                        acc  <= acc + prod;
                        rptr <= rptr + 1'b1;
                    end

                    if (kcnt == 9'(N_IN + 1)) begin
                        // Bias word: finish the sum and apply ReLU.
                        acc       <= sum;
                        out_data  <= sum[7] ? 8'd0 : sum;
                        out_valid <= 1'b1;
                        out_idx   <= node;
                        out_last  <= (node == 4'(N_NODES - 1));
                        state     <= OUT;
                    end
                end

                OUT: begin
                    // Result registers hold until the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (node == 4'(N_NODES - 1)) begin
                            state    <= LOAD;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state   <= RUN;
                            node    <= node + 1'b1;
                            acc     <= '0;
                            kcnt    <= '0;
                            rptr    <= '0;
                            w_rd_en <= 1'b1;
                            w_addr  <= w_addr + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_sched.sv
// tb/tb_layer_mac_sched.sv - scoreboard testbench for layer_mac_sched
`timescale 1ns/1ps

module tb_layer_mac_sched;

    localparam int N_IN    = 30;
    localparam int N_NODES = 16;
    localparam int PER     = N_IN + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        w_rd_en;
    logic [12:0] w_addr;
    logic [7:0]  w_data = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;

    layer_mac_sched #(.N_IN(N_IN), .N_NODES(N_NODES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    byte wmem [0:8191];
    byte acts [0:N_IN-1];

    // Weight memory: one-cycle read latency.
    always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];

    int   cyc = 0;
    logic reset_q = 1'b1, reset_qq = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        reset_qq <= reset_q;
        reset_q  <= reset;
    end

    typedef struct {
        logic [3:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;      // 0 always ready, 1 random, 2 hold node 3 for 10 cycles
    int hold_n = 0;
    int last_beat_cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: dot product of the frame with a neuron's weights plus bias,
    // reduced mod 256 and passed through ReLU on the 8-bit signed result.
    function automatic logic [7:0] model(input int n);
        int s = 0;
        for (int k = 0; k < N_IN; k++)
            s += int'(acts[k]) * int'(wmem[n*(N_IN+1)+k]);
        s += int'(wmem[n*(N_IN+1)+N_IN]);
        s = s & 255;
        return (s >= 128) ? 8'd0 : 8'(s);
    endfunction

    // out_ready driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (out_valid && out_idx == 4'd3 && hold_n < 10) begin
                    out_ready = 1'b0;
                    hold_n++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // Monitor / scoreboard
    int   node_exp = 0, k_exp = 0, vrise_prev = 0;
    logic prev_ov = 0, stab_valid = 0, hs_mid = 0, hs_last = 0;
    logic [7:0] s_data;
    logic [3:0] s_idx;
    logic       s_last;
    exp_t e;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (reset_q) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_idx", out_idx, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_w_rd_en", w_rd_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", in_ready, 0);
                exp_q.delete();
                node_exp = 0; k_exp = 0;
                prev_ov = 0; stab_valid = 0; hs_mid = 0; hs_last = 0;
            end else begin
                if (reset_qq) chk("in_ready_after_reset", in_ready, 1);
                if (in_ready) chk("busy_while_loading", busy, 0);
                if (hs_mid)  chk("next_run_starts", w_rd_en, 1);
                if (hs_last) chk("in_ready_after_last", in_ready, 1);
                if (out_valid) chk("no_read_in_out", w_rd_en, 0);
                if (w_rd_en) begin
                    chk("w_addr", w_addr, node_exp*(N_IN+1) + k_exp);
                    k_exp++;
                end
                if (stab_valid) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, s_data);
                    chk("hold_idx", out_idx, s_idx);
                    chk("hold_last", out_last, s_last);
                end
                stab_valid = out_valid && !out_ready;
                s_data = out_data; s_idx = out_idx; s_last = out_last;

                if (out_valid && !prev_ov) begin
                    if (rdy_mode == 0 && out_idx != 4'd0)
                        chk("out_spacing", cyc - vrise_prev, PER);
                    if (rdy_mode == 0 && out_last)
                        chk("frame_latency", cyc - last_beat_cyc, N_NODES*PER);
                    vrise_prev = cyc;
                end
                prev_ov = out_valid;

                hs_mid = 0; hs_last = 0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output_idx", out_idx, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_idx", out_idx, e.idx);
                        chk("out_data", out_data, e.data);
                        chk("out_last", out_last, e.last);
                    end
                    if (out_last) begin hs_last = 1; node_exp = 0; end
                    else begin hs_mid = 1; node_exp++; end
                    k_exp = 0;
                end
            end
        end
    end

    task automatic send_frame(input int gap_max);
        int t;
        for (int i = 0; i < N_IN; i++) begin
            repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = acts[i];
            t = 0;
            do begin
                @(posedge clk);
                t++;
            end while (!in_ready && t < 200);
            if (t >= 200) begin
                chk("in_accept", in_ready, 1);
                return;
            end
            if (i == N_IN - 1) last_beat_cyc = cyc;
            #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        if (gap_max > 0) begin
            // Offer junk while computing; it must not be taken.
            in_valid = 1'b1;
            repeat (5) begin
                in_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input bit use_const, input logic [7:0] cval);
        exp_t x;
        for (int n = 0; n < N_NODES; n++) begin
            x.idx  = 4'(n);
            x.data = use_const ? cval : model(n);
            x.last = (n == N_NODES - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic set_weights(input int w0, input int wk, input int bias);
        for (int n = 0; n < N_NODES; n++) begin
            for (int k = 0; k < N_IN; k++)
                wmem[n*(N_IN+1)+k] = byte'((k == 0) ? w0 : wk);
            wmem[n*(N_IN+1)+N_IN] = byte'(bias);
        end
    endtask

    task automatic random_weights();
        for (int i = 0; i < N_NODES*(N_IN+1); i++) wmem[i] = byte'($urandom);
        for (int k = 0; k < N_IN; k++) acts[k] = byte'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 8192; i++) wmem[i] = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Sum 465 wraps to 0xD1, negative -> 0
        set_weights(1, 1, 0);
        for (int k = 0; k < N_IN; k++) acts[k] = byte'(k + 1);
        rdy_mode = 0;
        push_expect(1, 8'h00);
        send_frame(0);
        wait_drain();

        // 60 - 7 = 53, with node 3 back-pressured
        set_weights(1, 1, -7);
        for (int k = 0; k < N_IN; k++) acts[k] = 8'sd2;
        rdy_mode = 2; hold_n = 0;
        push_expect(1, 8'h35);
        send_frame(0);
        wait_drain();
        chk("hold_cycles", hold_n, 10);

        // 16*16 truncates to 0; 16*7 = 0x70
        for (int k = 0; k < N_IN; k++) acts[k] = 0;
        acts[0] = 8'sd16;
        set_weights(16, 0, 0);
        rdy_mode = 0;
        push_expect(1, 8'h00);
        send_frame(0);
        wait_drain();
        set_weights(7, 0, 0);
        push_expect(1, 8'h70);
        send_frame(2);
        wait_drain();

        // Randomized frames against the reference model
        for (int f = 0; f < 3; f++) begin
            random_weights();
            rdy_mode = (f == 0) ? 0 : 1;
            push_expect(0, 8'h00);
            send_frame(3);
            wait_drain();
        end

        // Reset during neuron 5 computation
        random_weights();
        rdy_mode = 0;
        push_expect(0, 8'h00);
        send_frame(0);
        t = 0;
        while (!(node_exp == 5 && w_rd_en) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_node5", node_exp, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        random_weights();
        rdy_mode = 1;
        push_expect(0, 8'h00);
        send_frame(1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
